op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
- Sequencer for the 8-bit bit-serial logic datapath: register unit, compute unit and router.
- Queues up to DEPTH operation words {F,R} and, on one Execute press, runs them back-to-back.
- For each queued op it drives the F/R selects and asserts Shift_En for WIDTH cycles, with no bubble between ops.
- Gates register loads so that A and B cannot be loaded while a run is in progress. It takes the place of the single-op controller between the synchronizers and the datapath.

Parameters:
- WIDTH, 8: shift cycles per operation (register width).
- DEPTH, 4: op queue entries (power of 2).

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- LoadA  input  1  synchronized active-high load-A request (level)
- LoadB  input  1  synchronized active-high load-B request (level)
- Execute  input  1  synchronized active-high run request (level; acts on rising edge)
- Push  input  1  synchronized active-high enqueue request (level; acts on rising edge)
- F_In  input  3  function select to enqueue
- R_In  input  2  routing select to enqueue
- Ld_A  output  1  load strobe to register unit A
- Ld_B  output  1  load strobe to register unit B
- Shift_En  output  1  shift enable to register unit
- F_Out  output  3  function select to compute unit
- R_Out  output  2  routing select to router
- Busy  output  1  high in RUN or DONE
- Q_Count  output  $clog2(DEPTH)+1  queued entries
- Full  output  1  Q_Count == DEPTH
- Empty  output  1  Q_Count == 0
- Overflow  output  1  sticky: a push was dropped

Behaviour:
- Synchronous active-high reset. All state clears on the Clk edge where Reset = 1.
  - Reset values: Ld_A = 0, Ld_B = 0, Shift_En = 0, F_Out = 0, R_Out = 0, Busy = 0, Q_Count = 0, Full = 0, Empty = 1, Overflow = 0.
  - Queue is emptied and the FSM goes to IDLE.
  - Reset mid-run aborts immediately; Shift_En is 0 on the next cycle.
- Edge detection: internal registers Execute_q and Push_q. exec_rise = Execute & ~Execute_q; push_rise = Push & ~Push_q.
- Enqueue:
  - On push_rise with !Full, {F_In,R_In} is written at the tail and Q_Count increments. This is allowed in any state.
  - On push_rise with Full, the word is dropped and Overflow sets. Overflow clears only on Reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Ld_A = LoadA, Ld_B = LoadB (combinational). Shift_En = 0.
  - exec_rise with !Empty: pop the head into F_Out/R_Out, load shift counter cnt = WIDTH-1, go to RUN.
  - exec_rise with Empty: go to DONE without shifting (no Shift_En pulse).
- RUN:
  - Shift_En = 1. Ld_A = Ld_B = 0 regardless of LoadA/LoadB. cnt decrements each cycle.
  - When cnt == 0 and !Empty: pop the next head into F_Out/R_Out and reload cnt = WIDTH-1. Shift_En stays high with no gap.
  - When cnt == 0 and Empty: go to DONE.
  - The Empty check at cnt == 0 uses the registered Q_Count, so an op pushed in that same cycle is not run.
- DONE:
  - Shift_En = 0, Ld_A = Ld_B = 0.
  - Go to IDLE when Execute == 0. One Execute press runs the queue exactly once.
- Latency:
  - Execute first sampled high at edge n: Shift_En is high for cycles n+1 .. n+WIDTH×K, where K is the number of ops queued at launch plus any pushed early enough to be popped in time.
  - Busy falls one cycle after Execute is released in DONE.
- Simultaneous push_rise and pop in the same cycle: both take effect and Q_Count is unchanged. Push to a full queue during a pop cycle is accepted, because the pop frees an entry first.
- F_Out and R_Out hold the last executed op after a run, and update only on a pop.
- Pointers wrap modulo DEPTH.
- Q_Count, Full, Empty and Overflow are registered.

Optional Feature:
- Macro OPSEQ_OP_COUNTER_EN.
- Defined: adds output Ops_Done [7:0].
  - Increments by 1 at the end of each op's final shift cycle (cnt == 0 in RUN) and wraps 255 → 0.
  - Resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN, with 2 ops queued and cnt = 3 → next cycle: Shift_En = 0, Q_Count = 0, Empty = 1, F_Out = 0, FSM in IDLE.
- Push {F=3'b001, R=2'b00}, then press Execute at edge n → Shift_En is high for exactly cycles n+1..n+8, F_Out = 001, R_Out = 00. Busy stays high until Execute is released; Q_Count = 0 afterward.
- Push 3 ops (AND, OR, XOR: F = 000, 001, 010), then Execute → 24 contiguous Shift_En cycles. F_Out changes to 001 at cycle n+9 and to 010 at cycle n+17; no bubbles.
- Five pushes with DEPTH = 4 → Full = 1, Q_Count = 4, Overflow = 1. The 5th word is never executed (only 32 shift cycles).
- Hold LoadA = 1 during RUN → Ld_A = 0 throughout. LoadA = 1 in IDLE → Ld_A = 1 in the same cycle.
- Execute with an empty queue → Shift_En never asserts and Busy = 1 until Execute drops. With OPSEQ_OP_COUNTER_EN defined, Ops_Done stays 0, and becomes 3 after the three-op run.

Source files
------------

// File: rtl/op_sequencer.sv
// Op-queue sequencer for the bit-serial logic datapath: queues {F,R} words and runs them back-to-back.
// Optional macro OPSEQ_OP_COUNTER_EN adds the Ops_Done completed-op counter output.
module op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       LoadA,
    input  logic                       LoadB,
    input  logic                       Execute,
    input  logic                       Push,
    input  logic [2:0]                 F_In,
    input  logic [1:0]                 R_In,
    output logic                       Ld_A,
    output logic                       Ld_B,
    output logic                       Shift_En,
    output logic [2:0]                 F_Out,
    output logic [1:0]                 R_Out,
    output logic                       Busy,
    output logic [$clog2(DEPTH):0]     Q_Count,
    output logic                       Full,
    output logic                       Empty,
`ifdef OPSEQ_OP_COUNTER_EN
    output logic [7:0]                 Ops_Done,
`endif
    output logic                       Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = AW + 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic            execute_q;
    logic            push_q;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [4:0]      mem [DEPTH];

    logic            exec_rise;
    logic            push_rise;
    logic            last_shift;
    logic            pop_go;
    logic            push_go;
    logic [QW-1:0]   q_next;

    // Pop decisions use the registered Empty, so a word pushed on the same edge is never popped.
    always_comb begin
        exec_rise  = Execute & ~execute_q;
        push_rise  = Push & ~push_q;
        last_shift = (state == S_RUN) && (cnt == '0);
        pop_go     = ~Empty & (((state == S_IDLE) & exec_rise) | last_shift);
        push_go    = push_rise & (~Full | pop_go);
        q_next     = Q_Count + QW'(push_go) - QW'(pop_go);
    end

    assign Shift_En = (state == S_RUN);
    assign Busy     = (state != S_IDLE);
    assign Ld_A     = (state == S_IDLE) & LoadA;
    assign Ld_B     = (state == S_IDLE) & LoadB;

    always_ff @(posedge Clk) begin
        if (push_go)
            mem[tail] <= {F_In, R_In};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            execute_q <= 1'b0;
            push_q    <= 1'b0;
            cnt       <= '0;
            head      <= '0;
            tail      <= '0;
            F_Out     <= '0;
            R_Out     <= '0;
            Q_Count   <= '0;
            Full      <= 1'b0;
            Empty     <= 1'b1;
            Overflow  <= 1'b0;
`ifdef OPSEQ_OP_COUNTER_EN
            Ops_Done  <= '0;
`endif
        end else begin
            execute_q <= Execute;
            push_q    <= Push;
            Q_Count   <= q_next;
            Full      <= (q_next == QW'(DEPTH));
            Empty     <= (q_next == '0);
            if (push_rise & ~push_go)
                Overflow <= 1'b1;
            if (push_go)
                tail <= tail + AW'(1);
            if (pop_go) begin
                head           <= head + AW'(1);
                {F_Out, R_Out} <= mem[head];
            end
`ifdef OPSEQ_OP_COUNTER_EN
            if (last_shift)
                Ops_Done <= Ops_Done + 8'd1;
`endif
            case (state)
                S_IDLE: begin
                    if (exec_rise) begin
                        if (!Empty) begin
                            cnt   <= CW'(WIDTH - 1);
                            state <= S_RUN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt == '0) begin
                        if (!Empty)
                            cnt <= CW'(WIDTH - 1);
                        else
                            state <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (!Execute)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: queue-level behavioural model checked every cycle plus literal checkpoints.
module tb_op_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       Clk = 1'b0;
    logic       Reset, LoadA, LoadB, Execute, Push;
    logic [2:0] F_In;
    logic [1:0] R_In;
    logic       Ld_A, Ld_B, Shift_En, Busy, Full, Empty, Overflow;
    logic [2:0] F_Out;
    logic [1:0] R_Out;
    logic [2:0] Q_Count;
`ifdef OPSEQ_OP_COUNTER_EN
    logic [7:0] Ops_Done;
`endif

    op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB),
        .Execute(Execute), .Push(Push), .F_In(F_In), .R_In(R_In),
        .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En), .F_Out(F_Out),
        .R_Out(R_Out), .Busy(Busy), .Q_Count(Q_Count), .Full(Full),
        .Empty(Empty),
`ifdef OPSEQ_OP_COUNTER_EN
        .Ops_Done(Ops_Done),
`endif
        .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int shift_cnt = 0;
    bit armed = 0;

    // Model: a word queue, a phase (0 idle, 1 running, 2 done) and shift cycles left in the current op.
    logic [4:0] mq[$];
    int         m_phase, m_left, m_ops;
    logic [2:0] m_f;
    logic [1:0] m_r;
    bit         m_ovf, m_eq, m_pq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_pop();
        logic [4:0] w;
        w = mq.pop_front();
        m_f = w[4:2];
        m_r = w[1:0];
        m_left = WIDTH;
    endtask

    task automatic model_edge();
        bit er, pr;
        if (Reset) begin
            mq.delete();
            m_phase = 0; m_left = 0; m_ops = 0;
            m_f = 0; m_r = 0; m_ovf = 0; m_eq = 0; m_pq = 0;
            armed = 1;
            return;
        end
        er = Execute && !m_eq;
        pr = Push && !m_pq;
        case (m_phase)
            0: if (er) begin
                   if (mq.size() > 0) begin model_pop(); m_phase = 1; end
                   else m_phase = 2;
               end
            1: if (m_left == 1) begin
                   m_ops = (m_ops + 1) % 256;
                   if (mq.size() > 0) model_pop();
                   else m_phase = 2;
               end else begin
                   m_left--;
               end
            default: if (!Execute) m_phase = 0;
        endcase
        if (pr) begin
            if (mq.size() < DEPTH) mq.push_back({F_In, R_In});
            else m_ovf = 1;
        end
        m_eq = Execute;
        m_pq = Push;
    endtask

    task automatic compare_all();
        if (!armed) return;
        if (Shift_En === 1'b1) shift_cnt++;
        chk("shift_en", 32'(Shift_En), 32'(m_phase == 1));
        chk("busy",     32'(Busy),     32'(m_phase != 0));
        chk("ld_a",     32'(Ld_A),     32'(m_phase == 0 && LoadA));
        chk("ld_b",     32'(Ld_B),     32'(m_phase == 0 && LoadB));
        chk("f_out",    32'(F_Out),    32'(m_f));
        chk("r_out",    32'(R_Out),    32'(m_r));
        chk("q_count",  32'(Q_Count),  32'(mq.size()));
        chk("full",     32'(Full),     32'(mq.size() == DEPTH));
        chk("empty",    32'(Empty),    32'(mq.size() == 0));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
`ifdef OPSEQ_OP_COUNTER_EN
        chk("ops_done", 32'(Ops_Done), 32'(m_ops));
`endif
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic push_op(input logic [2:0] f, input logic [1:0] r);
        F_In = f; R_In = r; Push = 1'b1;
        step();
        Push = 1'b0;
        step();
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            if (Busy === 1'b1 && Shift_En === 1'b0) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'(0), 32'(1));
    endtask

    int s0;
`ifdef OPSEQ_OP_COUNTER_EN
    int o0;
`endif

    initial begin
        Reset = 1; LoadA = 0; LoadB = 0; Execute = 0; Push = 0; F_In = 0; R_In = 0;
        step(); step();
        chk("rst_shift_en", 32'(Shift_En), 32'(0));
        chk("rst_q_count",  32'(Q_Count),  32'(0));
        chk("rst_empty",    32'(Empty),    32'(1));
        chk("rst_busy",     32'(Busy),     32'(0));
        chk("rst_overflow", 32'(Overflow), 32'(0));
        Reset = 0;
        step();

        // Loads pass straight through in IDLE
        LoadA = 1; LoadB = 1; #1;
        chk("idle_ld_a", 32'(Ld_A), 32'(1));
        chk("idle_ld_b", 32'(Ld_B), 32'(1));
        step();
        LoadA = 0; LoadB = 0;
        step();

        // Single op
        push_op(3'b001, 2'b00);
        s0 = shift_cnt;
        Execute = 1;
        wait_done();
        chk("one_shifts", 32'(shift_cnt - s0), 32'(8));
        chk("one_f", 32'(F_Out), 32'(1));
        chk("one_r", 32'(R_Out), 32'(0));
        step(); step();
        chk("one_busy_held", 32'(Busy), 32'(1));
        Execute = 0;
        step();
        chk("one_busy_fall", 32'(Busy), 32'(0));
        chk("one_q_after", 32'(Q_Count), 32'(0));

        // Three ops back-to-back with LoadA held high
        push_op(3'b000, 2'b01);
        push_op(3'b001, 2'b10);
        push_op(3'b010, 2'b11);
`ifdef OPSEQ_OP_COUNTER_EN
        o0 = int'(Ops_Done);
`endif
        LoadA = 1;
        s0 = shift_cnt;
        Execute = 1;
        step();
        chk("three_first_shift", 32'(Shift_En), 32'(1));
        chk("three_ld_a_run", 32'(Ld_A), 32'(0));
        repeat (7) step();
        chk("three_f_n8", 32'(F_Out), 32'(0));
        step();
        chk("three_f_n9", 32'(F_Out), 32'(1));
        repeat (8) step();
        chk("three_f_n17", 32'(F_Out), 32'(2));
        wait_done();
        chk("three_shifts", 32'(shift_cnt - s0), 32'(24));
`ifdef OPSEQ_OP_COUNTER_EN
        chk("three_ops_done", 32'(int'(Ops_Done) - o0), 32'(3));
`endif
        Execute = 0;
        step();
        chk("three_ld_a_idle", 32'(Ld_A), 32'(1));
        LoadA = 0;
        step();

        // Push arriving mid-run is executed
        push_op(3'b100, 2'b01);
        s0 = shift_cnt;
        Execute = 1;
        step(); step();
        push_op(3'b101, 2'b10);
        wait_done();
        chk("mid_push_shifts", 32'(shift_cnt - s0), 32'(16));
        chk("mid_push_f", 32'(F_Out), 32'(5));
        Execute = 0;
        step();

        // Five pushes into four entries
        for (int i = 1; i <= 5; i++) push_op(3'(i), 2'(i));
        chk("ovf_full", 32'(Full), 32'(1));
        chk("ovf_q", 32'(Q_Count), 32'(4));
        chk("ovf_flag", 32'(Overflow), 32'(1));
        s0 = shift_cnt;
        Execute = 1;
        wait_done();
        chk("ovf_shifts", 32'(shift_cnt - s0), 32'(32));
        chk("ovf_last_f", 32'(F_Out), 32'(4));
        Execute = 0;
        step();

        // Execute on empty queue
`ifdef OPSEQ_OP_COUNTER_EN
        o0 = int'(Ops_Done);
`endif
        s0 = shift_cnt;
        Execute = 1;
        step();
        chk("empty_busy", 32'(Busy), 32'(1));
        repeat (3) step();
        chk("empty_busy_held", 32'(Busy), 32'(1));
        Execute = 0;
        step();
        chk("empty_busy_fall", 32'(Busy), 32'(0));
        chk("empty_shifts", 32'(shift_cnt - s0), 32'(0));
`ifdef OPSEQ_OP_COUNTER_EN
        chk("empty_ops_done", 32'(int'(Ops_Done) - o0), 32'(0));
`endif

        // Push landing on the final shift edge is not run
        push_op(3'b110, 2'b11);
        s0 = shift_cnt;
        Execute = 1;
        step();
        repeat (7) step();
        F_In = 3'b111; R_In = 2'b01; Push = 1;
        step();
        Push = 0;
        chk("late_push_done", 32'(Shift_En), 32'(0));
        chk("late_push_q", 32'(Q_Count), 32'(1));
        chk("late_push_shifts", 32'(shift_cnt - s0), 32'(8));
        Execute = 0;
        step(); step();

        // Reset mid-run: two ops remain queued with three shifts left in the current op
        push_op(3'b011, 2'b01);
        push_op(3'b010, 2'b10);
        Execute = 1;
        step();
        repeat (4) step();
        chk("pre_rst_q", 32'(Q_Count), 32'(2));
        Reset = 1; Execute = 0;
        step();
        Reset = 0;
        chk("mid_rst_shift_en", 32'(Shift_En), 32'(0));
        chk("mid_rst_q", 32'(Q_Count), 32'(0));
        chk("mid_rst_empty", 32'(Empty), 32'(1));
        chk("mid_rst_f", 32'(F_Out), 32'(0));
        chk("mid_rst_busy", 32'(Busy), 32'(0));
        chk("mid_rst_ovf", 32'(Overflow), 32'(0));
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
